// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the CPU data-memory port.
//
// Accepts one load/store per handshake from the MEM stage, issues word-aligned
// read/write accesses with byte strobes, waits for mem_ready_i and returns a
// sign- or zero-extended load result. Illegal func3 and (by default) misaligned
// accesses fault without touching memory.
//
// Build option: define MISALIGNED_SPLIT_EN to make misaligned H/W legal. Accesses
// that cross a word boundary are then split into two word accesses.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i / req_ready_o    request handshake (ready only in idle)
//   req_load_i, req_func3_i      load/store select, access width/extension
//   req_address_i, req_wdata_i   byte address, right-justified store data
//   rsp_valid_o                  one-cycle completion pulse
//   rsp_data_o, rsp_fault_o      load result (0 for stores/faults), fault flag
//   busy_o                       unit not idle, stalls the pipeline
//   mem_read_o, mem_write_o      access strobes, held until mem_ready_i
//   mem_address_o                word-aligned address
//   mem_wdata_o, mem_wstrb_o     lane-positioned store data and byte enables
//   mem_rdata_i, mem_ready_i     read word and access-complete from memory
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_load_i,
    input  logic [2:0]            req_func3_i,
    input  logic [ADDR_WIDTH-1:0] req_address_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_data_o,
    output logic                  rsp_fault_o,
    output logic                  busy_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_wstrb_o,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_ready_i
);

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  load_q;
    logic [2:0]            size_q;
    logic                  uns_q;
    logic                  cross_q;
    logic [31:0]           wdata_hi_q;
    logic [3:0]            wstrb_hi_q;
    logic [31:0]           rdata0_q;

    // Request decode
    logic [1:0]  dec_off;
    logic [2:0]  dec_size;
    logic [3:0]  dec_mask;
    logic        dec_illegal;
    logic        dec_misaligned;
    logic        dec_fault;
    logic        dec_cross;
    logic [63:0] dec_shift_data;
    logic [7:0]  dec_shift_strb;
    logic [31:0] dec_wdata_lo;

    always_comb begin
        dec_off     = req_address_i[1:0];
        dec_size    = 3'd4;
        dec_mask    = 4'b1111;
        dec_illegal = 1'b0;
        case (req_func3_i)
            3'b000: begin dec_size = 3'd1; dec_mask = 4'b0001; end
            3'b001: begin dec_size = 3'd2; dec_mask = 4'b0011; end
            3'b010: begin dec_size = 3'd4; dec_mask = 4'b1111; end
            3'b100: begin dec_size = 3'd1; dec_mask = 4'b0001; dec_illegal = !req_load_i; end
            3'b101: begin dec_size = 3'd2; dec_mask = 4'b0011; dec_illegal = !req_load_i; end
            default: dec_illegal = 1'b1;
        endcase
        dec_misaligned = (dec_size == 3'd2 && dec_off[0]) || (dec_size == 3'd4 && dec_off != 2'b00);
        dec_fault      = dec_illegal || (dec_misaligned && !SplitEn);
        dec_cross      = ({1'b0, dec_off} + dec_size) > 3'd4;
        // 64-bit lane view: low word feeds the first access, high word the second
        dec_shift_data = {32'b0, req_wdata_i} << {dec_off, 3'b000};
        dec_shift_strb = {4'b0, dec_mask} << dec_off;
        // Aligned B/H replicate across the word; misaligned fall back to shifted lanes
        if (dec_size == 3'd1) begin
            dec_wdata_lo = {4{req_wdata_i[7:0]}};
        end else if (dec_size == 3'd2 && !dec_off[0]) begin
            dec_wdata_lo = {2{req_wdata_i[15:0]}};
        end else begin
            dec_wdata_lo = dec_shift_data[31:0];
        end
    end

    function automatic logic [31:0] extend_load(input logic [63:0] raw, input logic [1:0] off,
                                                input logic [2:0] size, input logic uns);
        logic [31:0] sh;
        sh = 32'(raw >> {off, 3'b000});
        case (size)
            3'd1:    extend_load = uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            3'd2:    extend_load = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: extend_load = sh;
        endcase
    endfunction

    assign req_ready_o = (state_q == StIdle) && !rst_i;
    assign busy_o      = (state_q != StIdle);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            mem_read_o    <= 1'b0;
            mem_write_o   <= 1'b0;
            mem_wstrb_o   <= 4'b0;
            mem_wdata_o   <= 32'b0;
            mem_address_o <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_fault_o   <= 1'b0;
            rsp_data_o    <= 32'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    rsp_valid_o <= 1'b0;
                    if (req_valid_i) begin
                        addr_q     <= req_address_i;
                        load_q     <= req_load_i;
                        size_q     <= dec_size;
                        uns_q      <= req_func3_i[2];
                        cross_q    <= dec_cross;
                        wdata_hi_q <= dec_shift_data[63:32];
                        wstrb_hi_q <= req_load_i ? 4'b0 : dec_shift_strb[7:4];
                        if (dec_fault) begin
                            state_q     <= StResp;
                            rsp_valid_o <= 1'b1;
                            rsp_fault_o <= 1'b1;
                            rsp_data_o  <= 32'b0;
                        end else begin
                            state_q       <= StAcc0;
                            mem_address_o <= {req_address_i[ADDR_WIDTH-1:2], 2'b00};
                            mem_read_o    <= req_load_i;
                            mem_write_o   <= !req_load_i;
                            mem_wdata_o   <= req_load_i ? 32'b0 : dec_wdata_lo;
                            mem_wstrb_o   <= req_load_i ? 4'b0 : dec_shift_strb[3:0];
                        end
                    end
                end
                StAcc0: begin
                    if (mem_ready_i) begin
                        rdata0_q <= mem_rdata_i;
                        if (cross_q) begin
                            state_q       <= StAcc1;
                            // Wraps modulo 2^ADDR_WIDTH at the top of the space
                            mem_address_o <= {addr_q[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(1), 2'b00};
                            mem_wdata_o   <= load_q ? 32'b0 : wdata_hi_q;
                            mem_wstrb_o   <= wstrb_hi_q;
                        end else begin
                            state_q     <= StResp;
                            mem_read_o  <= 1'b0;
                            mem_write_o <= 1'b0;
                            mem_wstrb_o <= 4'b0;
                            rsp_valid_o <= 1'b1;
                            rsp_fault_o <= 1'b0;
                            rsp_data_o  <= load_q ?
                                extend_load({32'b0, mem_rdata_i}, addr_q[1:0], size_q, uns_q) : 32'b0;
                        end
                    end
                end
                StAcc1: begin
                    if (mem_ready_i) begin
                        state_q     <= StResp;
                        mem_read_o  <= 1'b0;
                        mem_write_o <= 1'b0;
                        mem_wstrb_o <= 4'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_fault_o <= 1'b0;
                        rsp_data_o  <= load_q ?
                            extend_load({mem_rdata_i, rdata0_q}, addr_q[1:0], size_q, uns_q) : 32'b0;
                    end
                end
                StResp: begin
                    rsp_valid_o <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the CPU data-memory port. Accepts one load/store per handshake from the MEM pipeline stage, drives word-aligned read/write accesses with byte strobes to data memory, waits for the memory acknowledge, and returns sign- or zero-extended load data. Misaligned and illegal accesses are detected here, so data memory only ever sees word-aligned addresses.

## Interface
- ADDR_WIDTH, 32, width of request and memory addresses.

- Clock  in  1  single clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- Req_valid  in  1  MEM stage presents a request.
- Req_ready  out  1  unit can accept; high only in IDLE.
- Req_load  in  1  1 = load, 0 = store.
- Req_func3  in  3  000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
- Req_address  in  ADDR_WIDTH  byte address.
- Req_wdata  in  32  store data, right-justified.
- Rsp_valid  out  1  one-cycle completion pulse.
- Rsp_data  out  32  extended load result; 0 for stores and faults.
- Rsp_fault  out  1  valid with Rsp_valid; misaligned or illegal func3.
- Busy  out  1  state != IDLE; pipeline stall.
- Mem_read / Mem_write  out  1 each  access strobes, never both high.
- Mem_address  out  ADDR_WIDTH  word-aligned, bits [1:0] always 0.
- Mem_wdata  out  32  lane-positioned store data.
- Mem_wstrb  out  4  byte enables; 0000 on reads.
- Mem_rdata  in  32  read word, valid when Mem_ready high during a read.
- Mem_ready  in  1  access complete this cycle.

## Operation
- FSM: IDLE, ACC0, ACC1, RESP.
- IDLE: on Req_valid && Req_ready, register request, offset = address[1:0], size = 1/2/4.
  - Illegal func3 (011, 110, 111, or 100/101 with store): RESP with fault; no memory access.
  - Misaligned (H with offset[0]=1, W with offset != 0): fault per Configuration.
  - Otherwise ACC0.
- ACC0: Mem_address = address & ~3. Strobes hold until Mem_ready=1. Then ACC1 if the access crosses a word boundary (offset + size > 4), else RESP.
- ACC1: Mem_address = (address & ~3) + 4, modulo 2^ADDR_WIDTH, so 0xFFFFFFFC wraps to 0. Then RESP on Mem_ready.
- Store lanes:
  - B: byte replicated x4, wstrb = 1 << offset.
  - H: halfword replicated x2, wstrb = 0011 or 1100.
  - W: wstrb 1111.
  - Split store: ACC0 enables lanes offset..3; ACC1 enables lanes 0..(offset+size-5); data shifted accordingly.
- Loads: select bytes from the captured Mem_rdata (both words if split), then sign-extend (B/H) or zero-extend (BU/HU).
- RESP: Rsp_valid=1 for exactly one cycle, then IDLE. Rsp_data/Rsp_fault hold until the next RESP.
- Reset (any state, including mid-access): state IDLE; Mem_read, Mem_write, Mem_wstrb, Rsp_valid, Rsp_fault, Rsp_data, Busy = 0. Req_ready is 0 while Reset is high. An aborted access produces no response.

## Timing
- Request accepted at edge N; ACC0 drives memory during cycle N+1.
- Zero-wait memory (Mem_ready high in the first access cycle): Rsp_valid in cycle N+2. Each wait cycle adds 1; a split access adds at least 1.
- Fault path: Rsp_valid in cycle N+1, no Mem_read/Mem_write ever asserted.
- Mem_* outputs are registered and stable for the full access; Mem_ready sampled at posedge.
- Next request accepted no earlier than the cycle after Rsp_valid.

## Configuration
- MISALIGNED_SPLIT_EN defined:
  - Misaligned H/W is legal. Accesses fitting in one word complete in one access (e.g. LH at offset 1, wstrb 0110).
  - Word-crossing accesses split into ACC0 + ACC1.
  - Rsp_fault only for illegal func3.
- Not defined: every misaligned access faults with no memory access; ACC1 is unreachable and may be removed.

## Test plan
- Zero-wait LW 0x100, Mem_rdata=0xDEADBEEF -> Mem_read in cycle N+1 with Mem_address=0x100; Rsp_valid in N+2, Rsp_data=0xDEADBEEF, Rsp_fault=0.
- SB 0x103, wdata=0x1A5, 2 wait cycles -> Mem_wdata=0xA5A5A5A5, wstrb=1000 held 3 cycles; Rsp_valid at N+4, Rsp_data=0.
- LB 0x102 / LBU 0x102, Mem_rdata=0x00800000 -> Rsp_data=0xFFFFFF80 / 0x00000080.
- LW 0x1FE:
  - With macro: reads 0x1FC (0x3344xxxx) then 0x200 (0xxxxx1122) -> Rsp_data=0x11223344.
  - Without macro: Rsp_fault=1 at N+1, no Mem_read.
- Req_func3=100 with store -> Rsp_fault=1, no Mem_write.
- Reset asserted during a stalled ACC0 -> Mem_read=0 next cycle, no Rsp_valid, Req_ready=1 the cycle after Reset deasserts.
